mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, meaning byte-address width on all address ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 i_req  input  1  instruction-fetch request; held until granted.
REQ-005 i_addr  input  ADDR_W  fetch byte address.
REQ-006 i_gnt  output  1  combinational; fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  one-cycle pulse; i_rdata valid.
REQ-008 i_rdata  output  32  fetched word.
REQ-009 i_err  output  1  one-cycle pulse; fetch rejected as misaligned.
REQ-010 d_req, d_we  input  1 each  data request; store when d_we=1, else load.
REQ-011 d_access  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010 only.
REQ-012 d_addr  input  ADDR_W; d_wdata  input  32.
REQ-013 d_gnt  output  1  combinational accept; d_rvalid  output  1  load-data pulse; d_rdata  output  32.
REQ-014 d_err  output  1  one-cycle pulse; data request rejected.
REQ-015 m_load, m_store  output  1 each  RAM strobes; m_access  output  3; m_addr  output  ADDR_W; m_wdata  output  32.
REQ-016 m_rdata  input  32  RAM read data, valid the cycle after m_load.

Function
REQ-017 At most one of m_load/m_store SHALL be high per cycle; each grant drives RAM for exactly one cycle.
REQ-018 Fetch grants SHALL drive m_load=1, m_access=010, m_addr=i_addr.
REQ-019 Data grants SHALL drive m_load=~d_we, m_store=d_we, m_access=d_access, m_addr=d_addr, m_wdata=d_wdata.
REQ-020 With no grant, RAM strobes SHALL be 0; m_addr/m_wdata/m_access SHALL be 0.
REQ-021 Single requester SHALL be granted in the same cycle (zero-cycle grant latency).
REQ-022 Conflict (i_req & d_req) SHALL be resolved by a 1-bit round-robin pointer: pointer=0 data wins, pointer=1 fetch wins; pointer flips only on a conflict grant.
REQ-023 Grants SHALL be issued every cycle (back-to-back); no idle cycle between accesses.
REQ-024 Load responses SHALL appear exactly one cycle after grant: owner's rvalid=1, rdata=m_rdata; the other rvalid=0.
REQ-025 Response routing SHALL use a registered tag {valid, owner} written at grant; stores write valid=0.
REQ-026 Stores SHALL complete at grant; no rvalid pulse.
REQ-027 Misalignment: fetch with i_addr[1:0]!=0; data LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
REQ-028 Illegal data access: d_access 011, 110, 111, or store with d_access[2]=1.
REQ-029 Misaligned or illegal requests SHALL be granted (gnt=1), consume their arbitration slot, issue no RAM strobe, and pulse err one cycle after grant.
REQ-030 err and rvalid of one port SHALL never be high in the same cycle.
REQ-031 rdata outputs SHALL be 0 when the corresponding rvalid is 0.

Reset
REQ-032 While rst=0: all outputs 0, pointer=0, response tag cleared.
REQ-033 Reset asserted with a response pending SHALL drop it; no rvalid/err after deassertion.
REQ-034 Requests high during the first cycle after deassertion SHALL be arbitrated normally.

Structure
REQ-035 Shared package mem_pkg SHALL hold access-code constants (ACC_LB..ACC_LHU), owner encoding (OWN_I, OWN_D), and the misalignment/legality function.
REQ-036 Round-robin decision SHALL live in sub-module rr_arb2 (req[1:0], pointer update, one-hot grant).
REQ-037 Output/tag datapath remains in mem_arbiter.

Verification
REQ-038 Fetch only, i_addr=0x100, RAM word 0xDEADBEEF -> i_gnt same cycle, m_load=1 m_access=010, next cycle i_rvalid=1 i_rdata=0xDEADBEEF.
REQ-039 i_req and d_req held 4 cycles after reset -> grant order D,I,D,I; m_load/m_store each cycle, no gaps.
REQ-040 d_we=1 d_access=001 d_addr=0x201 -> d_gnt=1, no m_store, d_err=1 next cycle, d_rvalid=0.
REQ-041 Store SW 0x12345678 @0x40 then LBU @0x43 back-to-back -> m_store then m_load consecutive; d_rvalid one cycle after load with m_rdata passed through.
REQ-042 rst driven low in the cycle after a fetch grant -> outputs 0 immediately, no i_rvalid after rst=1, next conflict data-first.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared access codes, owner encoding and request legality check.
//   ACC_*      : d_access encodings (LB, LH, LW, LBU, LHU)
//   OWN_I/OWN_D: response-tag owner (fetch port / data port)
//   bad_access : 1 when a request is illegal or misaligned and must not reach RAM
package mem_pkg;

    localparam logic [2:0] ACC_LB  = 3'b000;
    localparam logic [2:0] ACC_LH  = 3'b001;
    localparam logic [2:0] ACC_LW  = 3'b010;
    localparam logic [2:0] ACC_LBU = 3'b100;
    localparam logic [2:0] ACC_LHU = 3'b101;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Size is encoded in acc[1:0]; unsigned variants only exist for loads.
    function automatic logic bad_access(input logic we, input logic [2:0] acc, input logic [1:0] lo);
        logic illegal;
        logic misalign;
        illegal  = !(acc inside {ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU}) || (we && acc[2]);
        misalign = (acc[1:0] == 2'b10 && lo != 2'b00) || (acc[1:0] == 2'b01 && lo[0]);
        return illegal || misalign;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with zero-latency one-hot grant.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : requests (bit 0 = data port, bit 1 = fetch port)
//   gnt[1:0] : one-hot grant, same cycle as req
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr selects the conflict winner by index and toggles only on conflicts.
    logic ptr;

    always_comb gnt = (&req) ? (ptr ? 2'b10 : 2'b01) : req;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            ptr <= 1'b0;
        else if (&req)
            ptr <= ~ptr;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data ports.
//   clk, rst                         : clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt            : fetch request and same-cycle accept
//   i_rvalid/i_rdata/i_err           : fetch response / misalignment pulse, one cycle after grant
//   d_req/d_we/d_access/d_addr/d_wdata -> d_gnt : data request and same-cycle accept
//   d_rvalid/d_rdata/d_err           : load response / rejection pulse, one cycle after grant
//   m_load/m_store/m_access/m_addr/m_wdata, m_rdata : RAM strobes and read data (next cycle)
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_access,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_load,
    output logic              m_store,
    output logic [2:0]        m_access,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    logic [1:0] gnt;
    logic       i_bad, d_bad, i_go, d_go;
    logic       rsp_valid, rsp_owner;

    // Requests are masked during reset so the combinational grants stay low.
    rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .req({i_req & rst, d_req & rst}),
        .gnt(gnt)
    );

    always_comb begin
        i_gnt    = gnt[1];
        d_gnt    = gnt[0];
        i_bad    = bad_access(1'b0, ACC_LW, i_addr[1:0]);
        d_bad    = bad_access(d_we, d_access, d_addr[1:0]);
        i_go     = i_gnt & ~i_bad;
        d_go     = d_gnt & ~d_bad;
        m_load   = i_go | (d_go & ~d_we);
        m_store  = d_go & d_we;
        m_access = i_go ? ACC_LW : d_go ? d_access : 3'b000;
        m_addr   = i_go ? i_addr : d_go ? d_addr : '0;
        m_wdata  = d_go ? d_wdata : 32'h0;
        i_rvalid = rsp_valid && rsp_owner == OWN_I;
        d_rvalid = rsp_valid && rsp_owner == OWN_D;
        i_rdata  = i_rvalid ? m_rdata : 32'h0;
        d_rdata  = d_rvalid ? m_rdata : 32'h0;
    end

    // Response tag: only loads that actually reached RAM expect read data back.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_I;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            rsp_valid <= m_load;
            rsp_owner <= i_go ? OWN_I : OWN_D;
            i_err     <= i_gnt & i_bad;
            d_err     <= d_gnt & d_bad;
        end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed sequences and random traffic against a reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0, rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [2:0]  d_access = '0;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_load, m_store;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [2:0]  m_access;

    int n_cmp = 0, n_bad = 0;

    // Reference state: who is preferred on the next conflict, and what the
    // registered outputs must show on the following cycle.
    bit pref_i = 0;
    bit p_irv = 0, p_drv = 0, p_ie = 0, p_de = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_load(m_load), .m_store(m_store), .m_access(m_access), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [2:0]  da;
        logic [31:0] dd, wd;
        logic        eig, edg, eld, est;
        logic [2:0]  eacc;
        logic [31:0] eaddr;
        logic        nirv, ndrv, nie, nde;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Legal codes are byte/half/word loads plus signless stores; alignment by access size.
    function automatic bit bad_model(input bit we, input int acc, input int lo);
        int sz;
        if (!(acc inside {0, 1, 2, 4, 5})) return 1;
        if (we && acc >= 4) return 1;
        sz = (acc % 4 == 0) ? 1 : (acc % 4 == 1) ? 2 : 4;
        return (lo % sz) != 0;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "_strobes"}, 32'({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_load, m_store}), 32'h0);
        chk({name, "_data"}, i_rdata | d_rdata | m_addr | m_wdata | 32'(m_access), 32'h0);
    endtask

    // Check every output against the model mid-cycle, then advance one clock.
    task automatic step();
        bit wi, wd, ib, db, gi, gd;
        @(negedge clk);
        wi = i_req && (!d_req || pref_i);
        wd = d_req && !wi;
        ib = (i_addr % 4) != 0;
        db = bad_model(d_we, int'(d_access), int'(d_addr[1:0]));
        gi = wi && !ib;
        gd = wd && !db;
        chk("m_i_gnt", 32'(i_gnt), 32'(wi));
        chk("m_d_gnt", 32'(d_gnt), 32'(wd));
        chk("m_load", 32'(m_load), 32'(gi || (gd && !d_we)));
        chk("m_store", 32'(m_store), 32'(gd && d_we));
        chk("m_access", 32'(m_access), gi ? 32'd2 : gd ? 32'(d_access) : 32'd0);
        chk("m_addr", m_addr, gi ? i_addr : gd ? d_addr : 32'd0);
        chk("m_wdata", m_wdata, gd ? d_wdata : 32'd0);
        chk("m_i_rvalid", 32'(i_rvalid), 32'(p_irv));
        chk("m_d_rvalid", 32'(d_rvalid), 32'(p_drv));
        chk("m_i_rdata", i_rdata, p_irv ? m_rdata : 32'd0);
        chk("m_d_rdata", d_rdata, p_drv ? m_rdata : 32'd0);
        chk("m_i_err", 32'(i_err), 32'(p_ie));
        chk("m_d_err", 32'(d_err), 32'(p_de));
        @(posedge clk);
        p_irv = gi;
        p_drv = gd && !d_we;
        p_ie  = wi && ib;
        p_de  = wd && db;
        if (i_req && d_req) pref_i = !pref_i;
        #1;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_we = 0; d_access = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h102, 1'b0, 1'b0, 3'b000, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h44,  32'h5,  1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h44,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b001, 32'h201, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b001, 32'h201, 32'h9,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b000, 32'h203, 32'hAB, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b011, 32'h40,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b100, 32'h40,  32'h1,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b101, 32'h202, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 32'h202, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h46,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b111, 32'h40,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 3'b000, 32'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};

        // Reset: requests pending but everything must stay quiet.
        i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h44; d_access = 3'b010;
        #2 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Both ports held after reset: data first, then alternating.
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("rr_d_gnt", 32'(d_gnt), 32'(k % 2 == 0));
            chk("rr_i_gnt", 32'(i_gnt), 32'(k % 2 == 1));
            chk("rr_busy", 32'(m_load | m_store), 32'h1);
            step();
        end

        // Fetch only with RAM word 0xDEADBEEF.
        idle(); i_req = 1; i_addr = 32'h100;
        #3;
        chk("fetch_gnt", 32'(i_gnt), 32'h1);
        chk("fetch_load", 32'({m_load, m_access}), 32'b1010);
        chk("fetch_addr", m_addr, 32'h100);
        step();
        idle(); m_rdata = 32'hDEADBEEF;
        #3;
        chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        step();

        // Store word then byte load back-to-back.
        d_req = 1; d_we = 1; d_access = 3'b010; d_addr = 32'h40; d_wdata = 32'h12345678;
        #3;
        chk("sw_store", 32'({m_store, m_load}), 32'b10);
        chk("sw_wdata", m_wdata, 32'h12345678);
        step();
        d_we = 0; d_access = 3'b100; d_addr = 32'h43;
        #3;
        chk("lbu_load", 32'({m_store, m_load}), 32'b01);
        chk("lbu_addr", m_addr, 32'h43);
        chk("sw_no_rvalid", 32'(d_rvalid), 32'h0);
        step();
        idle(); m_rdata = 32'h12345678;
        #3;
        chk("lbu_rvalid", 32'(d_rvalid), 32'h1);
        chk("lbu_rdata", d_rdata, 32'h12345678);
        step();

        // Single-requester vector table with next-cycle response expectations.
        for (int v = 0; v < 12; v++) begin
            i_req = vecs[v].ir; i_addr = vecs[v].ia; d_req = vecs[v].dr; d_we = vecs[v].dw;
            d_access = vecs[v].da; d_addr = vecs[v].dd; d_wdata = vecs[v].wd; m_rdata = $urandom;
            #3;
            chk($sformatf("v%0d_gnt", v), 32'({i_gnt, d_gnt}), 32'({vecs[v].eig, vecs[v].edg}));
            chk($sformatf("v%0d_strobe", v), 32'({m_load, m_store}), 32'({vecs[v].eld, vecs[v].est}));
            chk($sformatf("v%0d_access", v), 32'(m_access), 32'(vecs[v].eacc));
            chk($sformatf("v%0d_addr", v), m_addr, vecs[v].eaddr);
            step();
            idle(); m_rdata = $urandom;
            #3;
            chk($sformatf("v%0d_resp", v), 32'({i_rvalid, d_rvalid, i_err, d_err}),
                32'({vecs[v].nirv, vecs[v].ndrv, vecs[v].nie, vecs[v].nde}));
            step();
        end

        // Random traffic, mostly aligned addresses.
        for (int c = 0; c < 400; c++) begin
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            d_access = 3'($urandom); d_wdata = $urandom; m_rdata = $urandom;
            i_addr = {$urandom_range(0, 255), 8'h0} | (($urandom % 4 == 0) ? 32'($urandom % 4) : 32'h0);
            d_addr = {$urandom_range(0, 255), 8'h0} | (($urandom % 3 == 0) ? 32'($urandom % 4) : 32'h0);
            step();
        end

        // Reset with a fetch response pending drops it; next conflict goes to data.
        idle(); i_req = 1; i_addr = 32'h100;
        step();
        d_req = 1; d_access = 3'b010; d_addr = 32'h80; m_rdata = 32'hDEADBEEF;
        #1 rst = 0;
        #1 chk_zero("rst_async");
        pref_i = 0; p_irv = 0; p_drv = 0; p_ie = 0; p_de = 0;
        @(posedge clk);
        #1 chk_zero("rst_held");
        rst = 1;
        #2;
        chk("rst_no_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_conflict_d", 32'({i_gnt, d_gnt}), 32'b01);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
